// File: rtl/riscv_multicycle_cpu.sv
// riscv_multicycle_cpu
// Multi-cycle RV32I integer core. Each instruction walks through
// IF -> ID -> EX -> (MEM) -> (WB) and then returns to IF.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   inst_addr / inst    instruction memory address (always PC) and word,
//                       one cycle of read latency
//   dm_write, dm_addr,  data memory write enable, byte address (ALU result
//   dm_data_in,         register), store data (latched rs2) and load data
//   dm_data_out         (one cycle of read latency)
//   watch_*             internal state exposed for simulation and debug
module riscv_multicycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  output logic        dm_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_data_in,
  input  logic [31:0] dm_data_out,
  output logic [3:0]  watch_stat,
  output logic [31:0] watch_pc,
  output logic [31:0] watch_ir,
  output logic [4:0]  watch_rs1,
  output logic [4:0]  watch_rs2,
  output logic [4:0]  watch_rd,
  output logic [31:0] watch_wb_data,
  output logic [31:0] watch_imm32,
  output logic [31:0] watch_lhs,
  output logic [31:0] watch_rhs,
  output logic [3:0]  watch_alu_op,
  output logic [31:0] watch_alu_f,
  output logic [3:0]  watch_alu_flags,
  output logic [31:0] watch_mdr,
  output logic [1:0]  watch_wb_data_sel,
  output logic [1:0]  watch_pc_update_sel
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_EX = 4'd3, S_MEM = 4'd4, S_WB = 4'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  state_t      state, state_next;
  logic [31:0] pc, old_pc, ir, a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic [3:0]  alu_op;
  logic [31:0] lhs, rhs, alu_f, wb_data, pc_next;
  logic [32:0] sum, diff;
  logic        flag_z, flag_n, flag_c, flag_v, branch_taken;
  logic [1:0]  wb_sel, pc_sel;

  // Sign-extended immediate for whichever RV32I format the opcode uses.
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    case (i[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR: imm_of = {{20{i[31]}}, i[31:20]};
      OPC_STORE:  imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH: imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm_of = {i[31:12], 12'b0};
      OPC_JAL:    imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:    imm_of = 32'd0;
    endcase
  endfunction

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);

  // ALU operation decode; IR[30] only selects SUB for register-register ops,
  // because for ADDI it is just an immediate bit.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_op || is_opimm) begin
      case (funct3)
        3'b000:  alu_op = (is_op && ir[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = ir[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (is_branch) begin
      alu_op = ALU_SUB;
    end
  end

  assign lhs = is_auipc ? old_pc : a_reg;
  assign rhs = (is_op || is_branch) ? b_reg : imm_reg;
  assign sum  = {1'b0, lhs} + {1'b0, rhs};
  assign diff = {1'b0, lhs} - {1'b0, rhs};

  // ALU and flags; the 33rd bit of diff is the unsigned borrow.
  always_comb begin
    alu_f  = 32'd0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_f  = sum[31:0];
        flag_c = sum[32];
        flag_v = (lhs[31] == rhs[31]) && (sum[31] != lhs[31]);
      end
      ALU_SUB: begin
        alu_f  = diff[31:0];
        flag_c = diff[32];
        flag_v = (lhs[31] != rhs[31]) && (diff[31] != lhs[31]);
      end
      ALU_SLL:  alu_f = lhs << rhs[4:0];
      ALU_SLT:  alu_f = {31'd0, $signed(lhs) < $signed(rhs)};
      ALU_SLTU: alu_f = {31'd0, lhs < rhs};
      ALU_XOR:  alu_f = lhs ^ rhs;
      ALU_SRL:  alu_f = lhs >> rhs[4:0];
      ALU_SRA:  alu_f = $signed(lhs) >>> rhs[4:0];
      ALU_OR:   alu_f = lhs | rhs;
      ALU_AND:  alu_f = lhs & rhs;
      default:  alu_f = 32'd0;
    endcase
  end

  assign flag_z = (alu_f == 32'd0);
  assign flag_n = alu_f[31];

  // Branch condition from the SUB flags of rs1 - rs2.
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = flag_z;
      3'b001:  branch_taken = !flag_z;
      3'b100:  branch_taken = flag_n ^ flag_v;
      3'b101:  branch_taken = !(flag_n ^ flag_v);
      3'b110:  branch_taken = flag_c;
      3'b111:  branch_taken = !flag_c;
      default: branch_taken = 1'b0;
    endcase
  end

  // Write-back and PC-update selects. During WB the load word is still on
  // dm_data_out (MDR captures it on the same edge), so it is forwarded.
  always_comb begin
    wb_sel = 2'd0;
    if (is_load) wb_sel = 2'd1;
    else if (is_jal || is_jalr) wb_sel = 2'd2;
    else if (is_lui) wb_sel = 2'd3;
    pc_sel = 2'd0;
    if (is_jal || (is_branch && branch_taken)) pc_sel = 2'd1;
    else if (is_jalr) pc_sel = 2'd2;
    case (wb_sel)
      2'd0:    wb_data = alu_out;
      2'd1:    wb_data = (state == S_WB) ? dm_data_out : mdr;
      2'd2:    wb_data = old_pc + 32'd4;
      default: wb_data = imm_reg;
    endcase
    case (pc_sel)
      2'd1:    pc_next = old_pc + imm_reg;
      2'd2:    pc_next = alu_f & ~32'd1;
      default: pc_next = pc + 32'd4;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else     state <= state_next;
  end

  // Next-state sequencing; unknown opcodes fall back to IF like a NOP.
  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_IF;
      S_IF:    state_next = S_ID;
      S_ID:    state_next = S_EX;
      S_EX: begin
        if (is_load || is_store) state_next = S_MEM;
        else if (is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr) state_next = S_WB;
        else state_next = S_IF;
      end
      S_MEM:   state_next = is_store ? S_IF : S_WB;
      S_WB:    state_next = S_IF;
      default: state_next = S_RESET;
    endcase
  end

  // Datapath registers and register file. Reset has priority so an
  // aborted instruction never writes the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      old_pc  <= 32'd0;
      ir      <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      imm_reg <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        S_ID: begin
          ir      <= inst;
          old_pc  <= pc;
          a_reg   <= regs[inst[19:15]];
          b_reg   <= regs[inst[24:20]];
          imm_reg <= imm_of(inst);
        end
        S_EX: begin
          alu_out <= alu_f;
          pc      <= pc_next;
        end
        S_WB: begin
          if (is_load) mdr <= dm_data_out;
          if (ir[11:7] != 5'd0) regs[ir[11:7]] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  // The write enable is gated by rst so a store aborted in MEM never lands.
  assign dm_write   = (state == S_MEM) && is_store && !rst;
  assign dm_addr    = alu_out;
  assign dm_data_in = b_reg;
  assign inst_addr  = pc;

  assign watch_stat          = state;
  assign watch_pc            = pc;
  assign watch_ir            = ir;
  assign watch_rs1           = ir[19:15];
  assign watch_rs2           = ir[24:20];
  assign watch_rd            = ir[11:7];
  assign watch_wb_data       = wb_data;
  assign watch_imm32         = imm_of(ir);
  assign watch_lhs           = lhs;
  assign watch_rhs           = rhs;
  assign watch_alu_op        = alu_op;
  assign watch_alu_f         = alu_f;
  assign watch_alu_flags     = {flag_z, flag_n, flag_c, flag_v};
  assign watch_mdr           = mdr;
  assign watch_wb_data_sel   = wb_sel;
  assign watch_pc_update_sel = pc_sel;

endmodule

// File: tb/tb_riscv_multicycle_cpu.sv
// tb_riscv_multicycle_cpu
// Self-checking bench for riscv_multicycle_cpu. A small program is placed in
// a synchronous instruction memory from a table of records; each record is
// stepped through and its state trace, next PC and IR are compared. Register
// write-backs and stores are checked by monitors against scoreboard queues
// filled as each instruction is issued. A hand-written sequence asserts
// reset during the MEM state of a store.
module tb_riscv_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr, inst, dm_addr, dm_data_in, dm_data_out;
  logic        dm_write;
  logic [3:0]  watch_stat, watch_alu_op, watch_alu_flags;
  logic [31:0] watch_pc, watch_ir, watch_wb_data, watch_imm32, watch_lhs, watch_rhs;
  logic [31:0] watch_alu_f, watch_mdr;
  logic [4:0]  watch_rs1, watch_rs2, watch_rd;
  logic [1:0]  watch_wb_data_sel, watch_pc_update_sel;

  riscv_multicycle_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst(inst),
    .dm_write(dm_write), .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_data_out(dm_data_out),
    .watch_stat(watch_stat), .watch_pc(watch_pc), .watch_ir(watch_ir),
    .watch_rs1(watch_rs1), .watch_rs2(watch_rs2), .watch_rd(watch_rd),
    .watch_wb_data(watch_wb_data), .watch_imm32(watch_imm32),
    .watch_lhs(watch_lhs), .watch_rhs(watch_rhs), .watch_alu_op(watch_alu_op),
    .watch_alu_f(watch_alu_f), .watch_alu_flags(watch_alu_flags), .watch_mdr(watch_mdr),
    .watch_wb_data_sel(watch_wb_data_sel), .watch_pc_update_sel(watch_pc_update_sel)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    inst <= imem[inst_addr[9:2]];
    if (dm_write) dmem[dm_addr[9:2]] <= dm_data_in;
    dm_data_out <= dmem[dm_addr[9:2]];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [23:0] trace;
    logic [31:0] next_pc;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] wb_val;
    logic        st;
    logic [31:0] st_addr;
    logic [31:0] st_data;
  } vec_t;

  localparam logic [23:0] T_ALU = 24'h001235, T_BR = 24'h000123;
  localparam logic [23:0] T_ST  = 24'h001234, T_LD = 24'h012345;

  vec_t        vecs[$];
  logic [36:0] wb_q[$];
  logic [63:0] st_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm[31:12], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic setVec(input logic [31:0] addr, input logic [31:0] instr, input logic [23:0] trace,
                        input logic [31:0] next_pc, input logic wb, input logic [4:0] rd,
                        input logic [31:0] wb_val, input logic st, input logic [31:0] st_addr,
                        input logic [31:0] st_data);
    vec_t v;
    v.addr = addr; v.instr = instr; v.trace = trace; v.next_pc = next_pc;
    v.wb = wb; v.rd = rd; v.wb_val = wb_val; v.st = st; v.st_addr = st_addr; v.st_data = st_data;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic waitStat(input logic [3:0] s, input int bound);
    int n = 0;
    while (watch_stat != s && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_stat", {28'd0, watch_stat}, {28'd0, s});
  endtask

  // Issues record i: pushes its expected effects, then steps from IF to the
  // next IF while recording the visited states and store pulses.
  task automatic applyStimulus(input int i, output logic [23:0] trace, output int ndw);
    int cyc = 0;
    if (vecs[i].wb) wb_q.push_back({vecs[i].rd, vecs[i].wb_val});
    if (vecs[i].st) st_q.push_back({vecs[i].st_addr, vecs[i].st_data});
    trace = 24'd0;
    ndw = 0;
    do begin
      trace = {trace[19:0], watch_stat};
      if (dm_write) ndw++;
      @(negedge clk);
      cyc++;
    end while (watch_stat != 4'd1 && cyc < 20);
    if (cyc >= 20) checkOutput("instr_timeout", 32'(cyc), 32'd0);
  endtask

  // Write-back monitor: every WB state retires one scoreboard entry.
  always @(negedge clk) begin
    if (watch_stat == 4'd5) begin
      if (wb_q.size() == 0) begin
        checkOutput("unexpected_wb_rd", {27'd0, watch_rd}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = wb_q.pop_front();
        checkOutput("wb_rd", {27'd0, watch_rd}, {27'd0, e[36:32]});
        checkOutput("wb_data", watch_wb_data, e[31:0]);
      end
    end
  end

  // Store monitor: every cycle with dm_write high must match a queued store.
  always @(negedge clk) begin
    if (dm_write) begin
      if (st_q.size() == 0) begin
        checkOutput("unexpected_store", {31'd0, dm_write}, 32'd0);
      end else begin
        logic [63:0] e;
        e = st_q.pop_front();
        checkOutput("store_addr", dm_addr, e[63:32]);
        checkOutput("store_data", dm_data_in, e[31:0]);
      end
    end
  end

  initial begin
    logic [23:0] trace;
    int          ndw;

    setVec(32'h00, enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), T_ALU, 32'h04, 1, 5'd1, 32'd5, 0, 0, 0);
    setVec(32'h04, enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, 7'b0010011), T_ALU, 32'h08, 1, 5'd2, 32'hFFFF_FFFD, 0, 0, 0);
    setVec(32'h08, enc_b(32'd8, 5'd1, 5'd1, 3'b000), T_BR, 32'h10, 0, 0, 0, 0, 0, 0);
    setVec(32'h10, enc_b(32'd8, 5'd1, 5'd1, 3'b001), T_BR, 32'h14, 0, 0, 0, 0, 0, 0);
    setVec(32'h14, enc_b(32'hFFFF_FFF8, 5'd1, 5'd2, 3'b100), T_BR, 32'h0C, 0, 0, 0, 0, 0, 0);
    setVec(32'h0C, enc_b(32'd16, 5'd1, 5'd2, 3'b111), T_BR, 32'h1C, 0, 0, 0, 0, 0, 0);
    setVec(32'h1C, enc_b(32'd8, 5'd1, 5'd2, 3'b110), T_BR, 32'h20, 0, 0, 0, 0, 0, 0);
    setVec(32'h20, enc_j(32'd12, 5'd5), T_ALU, 32'h2C, 1, 5'd5, 32'h24, 0, 0, 0);
    setVec(32'h2C, enc_i(32'd1, 5'd5, 3'b000, 5'd6, 7'b1100111), T_ALU, 32'h24, 1, 5'd6, 32'h30, 0, 0, 0);
    setVec(32'h24, enc_j(32'd16, 5'd0), T_ALU, 32'h34, 1, 5'd0, 32'h28, 0, 0, 0);
    setVec(32'h34, enc_s(32'd4, 5'd1, 5'd0), T_ST, 32'h38, 0, 0, 0, 1, 32'd4, 32'd5);
    setVec(32'h38, enc_i(32'd4, 5'd0, 3'b010, 5'd7, 7'b0000011), T_LD, 32'h3C, 1, 5'd7, 32'd5, 0, 0, 0);
    setVec(32'h3C, enc_i(32'd7, 5'd0, 3'b000, 5'd0, 7'b0010011), T_ALU, 32'h40, 1, 5'd0, 32'd7, 0, 0, 0);
    setVec(32'h40, enc_i(32'd1, 5'd0, 3'b000, 5'd4, 7'b0010011), T_ALU, 32'h44, 1, 5'd4, 32'd1, 0, 0, 0);
    setVec(32'h44, enc_u(32'h1234_5000, 5'd3, 7'b0110111), T_ALU, 32'h48, 1, 5'd3, 32'h1234_5000, 0, 0, 0);
    setVec(32'h48, enc_u(32'h0000_1000, 5'd8, 7'b0010111), T_ALU, 32'h4C, 1, 5'd8, 32'h0000_1048, 0, 0, 0);
    setVec(32'h4C, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), T_ALU, 32'h50, 1, 5'd9, 32'd2, 0, 0, 0);
    setVec(32'h50, enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd10), T_ALU, 32'h54, 1, 5'd10, 32'hFFFF_FFF8, 0, 0, 0);
    setVec(32'h54, enc_i(32'h401, 5'd2, 3'b101, 5'd11, 7'b0010011), T_ALU, 32'h58, 1, 5'd11, 32'hFFFF_FFFE, 0, 0, 0);
    setVec(32'h58, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd12), T_ALU, 32'h5C, 1, 5'd12, 32'd1, 0, 0, 0);
    setVec(32'h5C, enc_r(7'h00, 5'd4, 5'd1, 3'b001, 5'd13), T_ALU, 32'h60, 1, 5'd13, 32'd10, 0, 0, 0);
    setVec(32'h60, enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd14), T_ALU, 32'h64, 1, 5'd14, 32'd1, 0, 0, 0);

    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'd0;
      dmem[i] = 32'd0;
    end
    foreach (vecs[i]) imem[vecs[i].addr[9:2]] = vecs[i].instr;
    imem[8'h19] = enc_s(32'd12, 5'd1, 5'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stat", {28'd0, watch_stat}, 32'd0);
    checkOutput("reset_pc", watch_pc, 32'd0);
    checkOutput("reset_ir", watch_ir, 32'd0);
    checkOutput("reset_mdr", watch_mdr, 32'd0);
    checkOutput("reset_dm_write", {31'd0, dm_write}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitStat(4'd1, 5);

    foreach (vecs[i]) begin
      applyStimulus(i, trace, ndw);
      checkOutput($sformatf("trace_%0d", i), {8'd0, trace}, {8'd0, vecs[i].trace});
      checkOutput($sformatf("next_pc_%0d", i), watch_pc, vecs[i].next_pc);
      checkOutput($sformatf("ir_%0d", i), watch_ir, vecs[i].instr);
      checkOutput($sformatf("store_pulses_%0d", i), 32'(ndw), {31'd0, vecs[i].st});
      if (vecs[i].trace == T_LD) checkOutput("load_mdr", watch_mdr, 32'd5);
    end

    // Reset asserted while the store at 0x64 sits in MEM.
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_pre_stat", {28'd0, watch_stat}, 32'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_stat", {28'd0, watch_stat}, 32'd4);
    checkOutput("abort_dm_write", {31'd0, dm_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_stat", {28'd0, watch_stat}, 32'd0);
    checkOutput("abort_pc", watch_pc, 32'd0);
    checkOutput("abort_ir", watch_ir, 32'd0);
    checkOutput("abort_dmem", dmem[3], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitStat(4'd1, 5);
    applyStimulus(0, trace, ndw);
    checkOutput("rerun_trace", {8'd0, trace}, {8'd0, T_ALU});
    checkOutput("rerun_pc", watch_pc, 32'h04);

    checkOutput("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    checkOutput("store_queue_empty", 32'(st_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
